// File: rtl/dust16_pkg.sv
// Shared types and constants for the dust16 memory subsystem.
package dust16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  // Read data returned to a master whose cycle was aborted by the watchdog.
  localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

endpackage

// File: rtl/bus_watchdog.sv
// Bus timeout watchdog: counts consecutive stalled cycles of a granted access
// and flags expiry when the counter reaches all-ones. Clear has priority, so
// the counter never wraps; the arbiter clears it on the aborting completion.
module bus_watchdog #(
  parameter int unsigned TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  // Stall-cycle counter, cleared on completion or when no grant is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + TMO_W'(1);
  end

  assign expired = &cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared byte-wide memory bus.
// Optional feature: define MEM_ARB_LOCK_EN to keep the grant across a locked
// byte (atomic L/H word pairs); otherwise every byte is an arbitration point.
module mem_arbiter
  import dust16_pkg::*;
#(
  parameter int unsigned ADR_TOP = 15,
  parameter int unsigned TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [ADR_TOP:0] m0_addr,
  input  logic [7:0]       m0_outdata,
  input  logic             m0_lock,
  output logic             m0_wait,
  output logic [7:0]       m0_indata,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [ADR_TOP:0] m1_addr,
  input  logic [7:0]       m1_outdata,
  input  logic             m1_lock,
  output logic             m1_wait,
  output logic [7:0]       m1_indata,
  output logic             s_req,
  output logic             s_wr,
  output logic [ADR_TOP:0] s_addr,
  output logic [7:0]       s_outdata,
  input  logic [7:0]       s_indata,
  input  logic             s_wait,
  output logic             bus_err
);

  arb_state_t       state, state_nxt;
  logic             last, last_nxt;
  logic             granted, gx;
  logic             g_req, g_wr, other_req;
  logic [ADR_TOP:0] g_addr;
  logic [7:0]       g_data;
  logic             expired, abort, done, lock_hold;
  logic             g_wait;
  logic [7:0]       g_indata;

  assign granted   = (state != IDLE);
  assign gx        = (state == GNT1);
  assign g_req     = gx ? m1_req     : m0_req;
  assign g_wr      = gx ? m1_wr      : m0_wr;
  assign g_addr    = gx ? m1_addr    : m0_addr;
  assign g_data    = gx ? m1_outdata : m0_outdata;
  assign other_req = gx ? m0_req     : m1_req;

`ifdef MEM_ARB_LOCK_EN
  assign lock_hold = gx ? m1_lock : m0_lock;
`else
  logic lock_unused;
  assign lock_unused = m0_lock ^ m1_lock;
  assign lock_hold   = 1'b0;
`endif

  // A watchdog expiry completes the current byte on the master's behalf.
  assign abort = granted & g_req & expired;
  assign done  = granted & g_req & (~s_wait | expired);

  bus_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (~granted | done),
    .inc     (granted & g_req & s_wait),
    .expired (expired)
  );

  // Arbiter state and round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next grant: tie goes to the master not served last; completion re-arbitrates.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last ? GNT0 : GNT1;
        else if (m0_req)      state_nxt = GNT0;
        else if (m1_req)      state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!g_req) begin
          state_nxt = IDLE;
        end else if (done && !lock_hold) begin
          last_nxt = gx;
          if (other_req) state_nxt = gx ? GNT0 : GNT1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slave and master-side muxing from the granted master only.
  always_comb begin
    s_req     = 1'b0;
    s_wr      = 1'b0;
    s_addr    = '0;
    s_outdata = '0;
    bus_err   = 1'b0;
    m0_wait   = 1'b1;
    m1_wait   = 1'b1;
    m0_indata = '0;
    m1_indata = '0;
    g_wait    = abort ? 1'b0 : s_wait;
    g_indata  = abort ? BUS_ERR_DATA : s_indata;
    if (granted) begin
      s_req     = g_req & ~abort;
      s_wr      = g_wr;
      s_addr    = g_addr;
      s_outdata = g_data;
      bus_err   = abort;
      if (gx) begin
        m1_wait   = g_wait;
        m1_indata = g_indata;
      end else begin
        m0_wait   = g_wait;
        m0_indata = g_indata;
      end
    end
  end

endmodule
